tick_rate_ctrl: RTL and testbench

Single-clock controller that sequences the display counter datapath: replaces divided/muxed clocks with a one-cycle tick enable at a switch-selected rate.
Owns a run/pause/idle FSM driven by a debounced push button, and a wrapping BCD-style counter whose value feeds the 7-segment decoder.
Sits between board switches/buttons and num_to_seg; everything runs on clk.

---
 rtl/tick_ctrl_pkg.sv | 36 +++
 rtl/debounce_pulse.sv | 65 ++++++
 rtl/tick_rate_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tick_rate_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tick_ctrl_pkg
// Shared types and helpers for the tick rate controller.
//   state_t     : controller states (IDLE, RUN, PAUSE)
//   RATE_*      : rate select codes as seen on {sw2, sw1}
//   count_step  : one counter step (up or down) with wrap flag
// -----------------------------------------------------------------------------
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] RATE_HOLD = 2'b00;
    localparam logic [1:0] RATE_FAST = 2'b01;
    localparam logic [1:0] RATE_MED  = 2'b10;
    localparam logic [1:0] RATE_SLOW = 2'b11;

    // Returns {wrap, next_count}. Up-count wraps max->0, down-count wraps 0->max.
    function automatic logic [4:0] count_step(input logic [3:0] cur,
                                              input logic [3:0] max,
                                              input logic       down);
        logic [4:0] res;
        if (down) begin
            if (cur == 4'd0) res = {1'b1, max};
            else             res = {1'b0, cur - 4'd1};
        end else begin
            if (cur == max)  res = {1'b1, 4'd0};
            else             res = {1'b0, cur + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
// Synchronises a raw input with two flops and accepts a new level only after
// the synchronised value has disagreed with the accepted level for 2^DEB_W
// consecutive cycles. Any bounce back to the accepted level restarts the count.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   din        in   raw, asynchronous input
//   level      out  accepted (debounced) level
//   rise_pulse out  one-cycle pulse on an accepted 0->1 transition
// -----------------------------------------------------------------------------
module debounce_pulse #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            // The edge with the counter saturated is the 2^DEB_W-th differing cycle.
            if (cnt_q == {DEB_W{1'b1}}) begin
                level_d = s2_q;
                pulse_d = s2_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/tick_rate_ctrl.sv
// -----------------------------------------------------------------------------
// tick_rate_ctrl
// Generates a one-cycle count enable at a switch-selected rate, runs an
// IDLE/RUN/PAUSE state machine from a debounced button and keeps a wrapping
// 0..CNT_MAX counter for the 7-segment decoder. Single clock domain.
// Optional build macro: COUNT_DOWN_EN adds input 'dir' (1 = count down).
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   sw2,sw1  in   rate select {MSB,LSB}, raw/asynchronous
//   btn      in   run/pause button, raw, active-high
//   clr      in   synchronous clear back to IDLE
//   dir      in   count direction (only with COUNT_DOWN_EN)
//   tick     out  one-cycle count-enable pulse
//   cnt      out  counter value
//   wrap     out  one-cycle pulse when cnt wraps
//   running  out  high in RUN
//   rate     out  applied rate code
// -----------------------------------------------------------------------------
module tick_rate_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int DIV_FAST = 22,
    parameter int DEB_W    = 16,
    parameter int CNT_MAX  = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw2,
    input  logic       sw1,
    input  logic       btn,
    input  logic       clr,
`ifdef COUNT_DOWN_EN
    input  logic       dir,
`endif
    output logic       tick,
    output logic [3:0] cnt,
    output logic       wrap,
    output logic       running,
    output logic [1:0] rate
);

    localparam int         PW        = DIV_FAST + 2;
    localparam logic [3:0] CNT_MAX_L = 4'(CNT_MAX);

    logic [1:0]    sw_s1_q, sw_s1_d;
    logic [1:0]    sw_s2_q, sw_s2_d;
    logic [1:0]    rate_q, rate_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] term;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          running_q, running_d;
    logic          rate_chg;
    logic          count_down;
    logic          btn_level;
    logic          btn_rise;
    logic          press;

    debounce_pulse #(.DEB_W(DEB_W)) u_btn_deb (
        .clk        (clk),
        .rst        (rst),
        .din        (btn),
        .level      (btn_level),
        .rise_pulse (btn_rise)
    );

    // rise_pulse and level are set on the same edge, so this only guards
    // against acting on a pulse without an accepted high level.
    assign press = btn_rise & btn_level;

`ifdef COUNT_DOWN_EN
    assign count_down = dir;
`else
    assign count_down = 1'b0;
`endif

    // Prescaler terminal value (period-1) for the applied rate.
    always_comb begin
        case (rate_q)
            RATE_FAST: term = {2'b00, {DIV_FAST{1'b1}}};
            RATE_MED:  term = {1'b0, {(DIV_FAST + 1){1'b1}}};
            RATE_SLOW: term = {PW{1'b1}};
            default:   term = '0;
        endcase
    end

    assign rate_chg = (sw_s2_q != rate_q);

    always_comb begin
        sw_s1_d = {sw2, sw1};
        sw_s2_d = sw_s1_q;
        rate_d  = rate_q;
        presc_d = presc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (rate_chg) rate_d = sw_s2_q;

        if (clr) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (press) state_d = RUN;
                end
                RUN: begin
                    // A rate change restarts the period and suppresses the tick.
                    if (rate_chg) begin
                        presc_d = '0;
                    end else if (rate_q != RATE_HOLD) begin
                        if (presc_q == term) begin
                            presc_d         = '0;
                            tick_d          = 1'b1;
                            {wrap_d, cnt_d} = count_step(cnt_q, CNT_MAX_L, count_down);
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                    if (press) state_d = PAUSE;
                end
                PAUSE: begin
                    // Prescaler holds so the phase survives the pause.
                    if (rate_chg) presc_d = '0;
                    if (press) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q   <= 2'b00;
            sw_s2_q   <= 2'b00;
            rate_q    <= RATE_HOLD;
            presc_q   <= '0;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            rate_q    <= rate_d;
            presc_q   <= presc_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign tick    = tick_q;
    assign cnt     = cnt_q;
    assign wrap    = wrap_q;
    assign running = running_q;
    assign rate    = rate_q;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tick_rate_ctrl
// Directed bench for tick_rate_ctrl with DIV_FAST=2, DEB_W=2, CNT_MAX=9:
// fast period 4, slow period 16, button accepted 7 edges after it is driven.
// -----------------------------------------------------------------------------
module tb_tick_rate_ctrl;

    logic       clk;
    logic       rst;
    logic       sw2;
    logic       sw1;
    logic       btn;
    logic       clr;
`ifdef COUNT_DOWN_EN
    logic       dir;
`endif
    logic       tick;
    logic [3:0] cnt;
    logic       wrap;
    logic       running;
    logic [1:0] rate;

    int n_checks = 0;
    int n_pass   = 0;

    tick_rate_ctrl #(.DIV_FAST(2), .DEB_W(2), .CNT_MAX(9)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw2     (sw2),
        .sw1     (sw1),
        .btn     (btn),
        .clr     (clr),
`ifdef COUNT_DOWN_EN
        .dir     (dir),
`endif
        .tick    (tick),
        .cnt     (cnt),
        .wrap    (wrap),
        .running (running),
        .rate    (rate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sw2 = 1'b0; sw1 = 1'b0; btn = 1'b0; clr = 1'b0;
`ifdef COUNT_DOWN_EN
        dir = 1'b0;
`endif
        repeat (3) step();
        n_checks++;
        if ({tick, wrap, running} !== 3'b000) $display("FAIL reset_flags tick/wrap/running=%b%b%b expected 000", tick, wrap, running);
        else n_pass++;
        n_checks++;
        if (cnt !== 4'd0 || rate !== 2'b00) $display("FAIL reset_cnt_rate cnt=%0d rate=%b expected 0/00", cnt, rate);
        else n_pass++;
        rst = 1'b0;
    endtask

    // Start at rate 01, press, then ten ticks with a wrap on the tenth.
    task automatic test_run_ticks();
        logic bad;
        {sw2, sw1} = 2'b01;
        btn = 1'b1;
        repeat (3) step();
        n_checks++;
        if (rate !== 2'b01) $display("FAIL rate_load rate=%b expected 01", rate);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (running !== 1'b0) $display("FAIL press_early running=%b expected 0", running);
        else n_pass++;
        step();
        n_checks++;
        if (running !== 1'b1 || cnt !== 4'd0) $display("FAIL press_latency running=%b cnt=%0d expected 1/0", running, cnt);
        else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            bad = 1'b0;
            for (int j = 1; j <= 4; j++) begin
                step();
                if (k == 1 && j == 3) btn = 1'b0;
                if (j < 4 && (tick !== 1'b0 || wrap !== 1'b0)) bad = 1'b1;
            end
            n_checks++;
            if (bad || tick !== 1'b1 || cnt !== 4'(k % 10) || wrap !== (k == 10))
                $display("FAIL tick_seq_%0d cnt=%0d tick=%b wrap=%b early=%b expected cnt=%0d tick=1 wrap=%0d early=0",
                         k, cnt, tick, wrap, bad, k % 10, (k == 10));
            else n_pass++;
        end
    endtask

    // Change 01 -> 11 so the load lands exactly on the would-be tick edge.
    task automatic test_rate_change();
        logic bad;
        step();
        n_checks++;
        if (tick !== 1'b0 || wrap !== 1'b0) $display("FAIL pulse_width tick=%b wrap=%b expected 0/0", tick, wrap);
        else n_pass++;
        {sw2, sw1} = 2'b11;
        repeat (3) step();
        n_checks++;
        if (rate !== 2'b11 || tick !== 1'b0 || cnt !== 4'd0) $display("FAIL rate_chg_edge rate=%b tick=%b cnt=%0d expected 11/0/0", rate, tick, cnt);
        else n_pass++;
        bad = 1'b0;
        repeat (15) begin
            step();
            if (tick !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL slow_gap early_tick=%b expected 0", bad);
        else n_pass++;
        step();
        n_checks++;
        if (tick !== 1'b1 || cnt !== 4'd1) $display("FAIL slow_tick tick=%b cnt=%0d expected 1/1", tick, cnt);
        else n_pass++;
    endtask

    // Pause with prescaler at 1, then resume: first tick three edges later.
    task automatic test_pause_resume();
        logic bad;
        {sw2, sw1} = 2'b01;
        repeat (3) step();
        n_checks++;
        if (rate !== 2'b01 || tick !== 1'b0) $display("FAIL rate_back rate=%b tick=%b expected 01/0", rate, tick);
        else n_pass++;
        repeat (2) step();
        btn = 1'b1;
        repeat (6) step();
        n_checks++;
        if (tick !== 1'b1 || cnt !== 4'd3 || running !== 1'b1) $display("FAIL pre_pause tick=%b cnt=%0d running=%b expected 1/3/1", tick, cnt, running);
        else n_pass++;
        step();
        n_checks++;
        if (running !== 1'b0 || tick !== 1'b0) $display("FAIL pause_entry running=%b tick=%b expected 0/0", running, tick);
        else n_pass++;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) btn = 1'b0;
            step();
            if (tick !== 1'b0 || cnt !== 4'd3 || running !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL pause_hold activity=%b expected 0", bad);
        else n_pass++;
        btn = 1'b1;
        repeat (7) step();
        n_checks++;
        if (running !== 1'b1 || tick !== 1'b0) $display("FAIL resume running=%b tick=%b expected 1/0", running, tick);
        else n_pass++;
        bad = 1'b0;
        repeat (2) begin
            step();
            if (tick !== 1'b0) bad = 1'b1;
        end
        step();
        n_checks++;
        if (bad || tick !== 1'b1 || cnt !== 4'd4) $display("FAIL resume_phase early=%b tick=%b cnt=%0d expected 0/1/4", bad, tick, cnt);
        else n_pass++;
        btn = 1'b0;
        repeat (10) step();
        n_checks++;
        if (running !== 1'b1) $display("FAIL release_quiet running=%b expected 1", running);
        else n_pass++;
    endtask

    // Bouncing button, then stable high: one accepted press only.
    task automatic test_bounce();
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn = (i % 2 == 0);
            step();
            if (running !== 1'b1) bad = 1'b1;
        end
        btn = 1'b1;
        repeat (6) begin
            step();
            if (running !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL bounce_reject state_changed=%b expected 0", bad);
        else n_pass++;
        step();
        n_checks++;
        if (running !== 1'b0) $display("FAIL bounce_accept running=%b expected 0", running);
        else n_pass++;
        bad = 1'b0;
        repeat (20) begin
            step();
            if (running !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL hold_single_press extra_change=%b expected 0", bad);
        else n_pass++;
        btn = 1'b0;
    endtask

    // clr, press and the tick condition all on one edge.
    task automatic test_clr();
        logic bad;
        int   n;
        repeat (10) step();
        btn = 1'b1;
        repeat (7) step();
        n_checks++;
        if (running !== 1'b1) $display("FAIL clr_setup running=%b expected 1", running);
        else n_pass++;
        btn = 1'b0;
        repeat (8) step();
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 10);
        n_checks++;
        if (tick !== 1'b1) $display("FAIL clr_find_tick tick=%b after %0d cycles expected 1", tick, n);
        else n_pass++;
        step();
        btn = 1'b1;
        repeat (6) step();
        clr = 1'b1;
        step();
        n_checks++;
        if (running !== 1'b0 || cnt !== 4'd0 || tick !== 1'b0 || wrap !== 1'b0)
            $display("FAIL clr_priority running=%b cnt=%0d tick=%b wrap=%b expected 0/0/0/0", running, cnt, tick, wrap);
        else n_pass++;
        clr = 1'b0;
        btn = 1'b0;
        bad = 1'b0;
        repeat (15) begin
            step();
            if (tick !== 1'b0 || cnt !== 4'd0 || running !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL clr_idle activity=%b expected 0", bad);
        else n_pass++;
    endtask

    // Asynchronous reset between edges while counting at cnt=5.
    task automatic test_async_reset();
        logic bad;
        int   n;
        btn = 1'b1;
        repeat (7) step();
        btn = 1'b0;
        n = 0;
        while (cnt !== 4'd5 && n < 60) begin
            step();
            n++;
        end
        n_checks++;
        if (cnt !== 4'd5 || running !== 1'b1) $display("FAIL areset_setup cnt=%0d running=%b expected 5/1", cnt, running);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (cnt !== 4'd0 || {tick, wrap, running} !== 3'b000 || rate !== 2'b00)
            $display("FAIL areset_immediate cnt=%0d tick/wrap/running=%b%b%b rate=%b expected 0/000/00", cnt, tick, wrap, running, rate);
        else n_pass++;
        #2;
        rst = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            step();
            if (tick !== 1'b0 || cnt !== 4'd0 || running !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || rate !== 2'b01) $display("FAIL areset_idle activity=%b rate=%b expected 0/01", bad, rate);
        else n_pass++;
`ifdef COUNT_DOWN_EN
        dir = 1'b1;
        btn = 1'b1;
        repeat (7) step();
        btn = 1'b0;
        repeat (4) step();
        n_checks++;
        if (tick !== 1'b1 || cnt !== 4'd9 || wrap !== 1'b1) $display("FAIL down_wrap tick=%b cnt=%0d wrap=%b expected 1/9/1", tick, cnt, wrap);
        else n_pass++;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_run_ticks();
        test_rate_change();
        test_pause_resume();
        test_bounce();
        test_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
